// File: rtl/ar_mux_pkg.sv
// Shared constants for the writable lookup-table mux: default geometry and
// the init-sequencer state encodings.
package ar_mux_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_INIT_VAL = 10;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/ar_mux_init_seq.sv
// Init sequencer: after reset walks init_cnt over every table entry, one per
// cycle, then parks in RUN. busy is a pure register decode.
module ar_mux_init_seq
  import ar_mux_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  output logic             init_we,
  output logic [SEL_W-1:0] init_addr
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(DEPTH - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] init_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == LAST) begin
        state    <= ST_RUN;
        init_cnt <= '0;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  assign busy      = (state == ST_INIT);
  // No fill write lands while reset is still held.
  assign init_we   = busy && !rst;
  assign init_addr = init_cnt;

endmodule

// File: rtl/ar_mux_tbl.sv
// Writable DEPTH-entry lookup table read through a registered select mux.
// Define AR_MUX_TBL_BYPASS_EN for write-through on same-address read/write.
module ar_mux_tbl
  import ar_mux_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SEL_W    = $clog2(DEPTH),
  parameter int INIT_VAL = DEF_INIT_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  sel,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              rd_err,
  output logic              busy
);

  // Storage is sized to the full select range so any select value indexes
  // safely; entries at or above DEPTH are never written or returned.
  localparam int MEM_N = 1 << SEL_W;

  function automatic logic in_range(input logic [SEL_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  logic [DATA_W-1:0] mem [0:MEM_N-1];

  logic              init_we;
  logic [SEL_W-1:0]  init_addr;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] rd_word;

  ar_mux_init_seq #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_data = wr_data;
    if (busy) begin
      mem_we   = init_we;
      mem_addr = init_addr;
      mem_data = DATA_W'(INIT_VAL);
    end else begin
      mem_we   = wr_en && !rst && in_range(wr_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  always_comb begin
`ifdef AR_MUX_TBL_BYPASS_EN
    rd_word = (wr_en && (wr_addr == sel)) ? wr_data : mem[sel];
`else
    rd_word = mem[sel];
`endif
  end

  // Read/output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      rd_err  <= 1'b0;
    end else if (rd_en && !busy) begin
      q_valid <= 1'b1;
      if (in_range(sel)) begin
        q      <= rd_word;
        rd_err <= 1'b0;
      end else begin
        q      <= '0;
        rd_err <= 1'b1;
      end
    end else begin
      q_valid <= 1'b0;
      rd_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ar_mux_tbl.sv
// Bench for ar_mux_tbl: a DEPTH=8 and a DEPTH=5 instance share stimulus and
// are both tracked by an array-based reference model every cycle.
module tb_ar_mux_tbl;

`ifdef AR_MUX_TBL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, rd_en, wr_en;
  logic [2:0] sel, wr_addr;
  logic [7:0] wr_data;
  logic [7:0] q8, q5;
  logic       qv8, qv5, e8, e5, b8, b5;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ar_mux_tbl #(.DATA_W(8), .DEPTH(8), .INIT_VAL(10)) u8 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .sel(sel), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .q(q8), .q_valid(qv8),
    .rd_err(e8), .busy(b8)
  );

  ar_mux_tbl #(.DATA_W(8), .DEPTH(5), .INIT_VAL(10)) u5 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .sel(sel), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .q(q5), .q_valid(qv5),
    .rd_err(e5), .busy(b5)
  );

  // Reference model: table contents plus remaining init cycles per instance
  int         dep [2] = '{8, 5};
  int         ileft [2];
  logic [7:0] mm [2][8];
  logic [7:0] eq [2];
  logic       ev [2];
  logic       ee [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ileft[k] = dep[k];
        eq[k] = 8'd0; ev[k] = 1'b0; ee[k] = 1'b0;
      end else if (ileft[k] > 0) begin
        mm[k][dep[k] - ileft[k]] = 8'd10;
        ileft[k]--;
        ev[k] = 1'b0; ee[k] = 1'b0;
      end else begin
        if (rd_en) begin
          ev[k] = 1'b1;
          if (int'(sel) >= dep[k]) begin
            eq[k] = 8'd0; ee[k] = 1'b1;
          end else begin
            ee[k] = 1'b0;
            eq[k] = (BYP && wr_en && wr_addr == sel) ? wr_data : mm[k][sel];
          end
        end else begin
          ev[k] = 1'b0; ee[k] = 1'b0;
        end
        if (wr_en && int'(wr_addr) < dep[k]) mm[k][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("m_q8", q8, eq[0]);   chk("m_qv8", qv8, ev[0]);
    chk("m_err8", e8, ee[0]); chk("m_busy8", b8, ileft[0] > 0);
    chk("m_q5", q5, eq[1]);   chk("m_qv5", qv5, ev[1]);
    chk("m_err5", e5, ee[1]); chk("m_busy5", b5, ileft[1] > 0);
  endtask

  task automatic idle();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_init(input int expect_len, input string name);
    int cnt = 0;
    while (b8 && cnt < 40) begin
      cycle();
      cnt++;
    end
    chk(name, cnt, expect_len);
  endtask

  typedef struct {
    logic       rd, wr;
    logic [2:0] sel, wa;
    logic [7:0] wd;
    logic [7:0] q8;
    logic       v8, er8;
    logic [7:0] q5;
    logic       v5, er5;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] coll;
    coll = BYP ? 8'h3C : 8'd10;
    tbl[0] = '{1, 1, 3'd0, 3'd3, 8'hA5, 8'd10, 1, 0, 8'd10, 1, 0};
    tbl[1] = '{1, 0, 3'd3, 3'd0, 8'h00, 8'hA5, 1, 0, 8'hA5, 1, 0};
    tbl[2] = '{1, 0, 3'd4, 3'd0, 8'h00, 8'd10, 1, 0, 8'd10, 1, 0};
    tbl[3] = '{1, 1, 3'd2, 3'd2, 8'h3C, coll,  1, 0, coll,  1, 0};
    tbl[4] = '{1, 0, 3'd2, 3'd0, 8'h00, 8'h3C, 1, 0, 8'h3C, 1, 0};
    tbl[5] = '{0, 0, 3'd0, 3'd0, 8'h00, 8'h3C, 0, 0, 8'h3C, 0, 0};
    tbl[6] = '{1, 1, 3'd6, 3'd7, 8'hAA, 8'd10, 1, 0, 8'd0,  1, 1};
    tbl[7] = '{1, 0, 3'd7, 3'd0, 8'h00, 8'hAA, 1, 0, 8'd0,  1, 1};

    idle(); sel = '0; wr_addr = '0; wr_data = '0;
    for (int k = 0; k < 2; k++) begin
      ileft[k] = dep[k];
      for (int i = 0; i < 8; i++) mm[k][i] = 8'hxx;
    end

    // Reset and init fill
    rst = 1'b1;
    cycle();
    chk("rst_busy", b8, 1'b1);
    chk("rst_q", q8, 8'd0);
    chk("rst_qv", qv8, 1'b0);
    rst = 1'b0;
    wait_init(8, "init_len8");
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; sel = 3'(i);
      cycle();
      chk("init_rd8", {qv8, e8, q8}, {1'b1, 1'b0, 8'd10});
    end
    idle();

    // Directed table: write/read, collision, out-of-range on DEPTH=5
    for (int i = 0; i < 8; i++) begin
      rd_en = tbl[i].rd; wr_en = tbl[i].wr; sel = tbl[i].sel;
      wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      cycle();
      chk("tbl_d8", {qv8, e8, q8}, {tbl[i].v8, tbl[i].er8, tbl[i].q8});
      chk("tbl_d5", {qv5, e5, q5}, {tbl[i].v5, tbl[i].er5, tbl[i].q5});
    end
    idle();

    // Requests during init are dropped
    rst = 1'b1;
    cycle();
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF; sel = 3'd1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("busy_drop_qv8", qv8, 1'b0);
    end
    wr_en = 1'b0;
    cycle();
    chk("busy_drop_rd1", {qv8, q8}, {1'b1, 8'd10});
    idle();

    // Reset with a read in flight
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1; sel = 3'd0;
    cycle();
    chk("mid_rd0", q8, 8'h55);
    sel = 3'd1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("mid_rst", {qv8, q8}, {1'b0, 8'd0});
    idle();
    wait_init(8, "reinit_len8");
    rd_en = 1'b1; sel = 3'd0;
    cycle();
    chk("reinit_rd0", {qv8, q8}, {1'b1, 8'd10});
    idle();

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      rd_en   = 1'($urandom);
      wr_en   = 1'($urandom);
      sel     = 3'($urandom);
      wr_addr = ($urandom_range(0, 3) == 0) ? sel : 3'($urandom);
      wr_data = 8'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
